// File: rtl/clause_load_scan_controller.sv
// Purpose: loads N packed clause words into the clause bank in order, then sweeps clause indices for the evaluator.
// Latency: accepted word appears as a one-hot write pulse 1 cycle later; scan index is valid on the cycle after the request.
// Backpressure: coefficient input is valid/ready (ready only in LOAD); scan index is held while in_scan_stall is high.
module clause_load_scan_controller #(
  parameter int BIT_WIDTH_OF_INTEGER_VARIABLE = 2,
  parameter int NUMBER_OF_INTEGER_VARIABLES   = 2,
  parameter int NUMBER_OF_CLAUSES             = 4,
  parameter int CLAUSE_INDEX_WIDTH            = 2
) (
  input  logic                                                             in_clk,
  input  logic                                                             in_reset,
  input  logic                                                             in_start,
  input  logic                                                             in_coeff_valid,
  input  logic [BIT_WIDTH_OF_INTEGER_VARIABLE*NUMBER_OF_INTEGER_VARIABLES-1:0] in_coefficients,
  output logic                                                             out_coeff_ready,
  output logic [BIT_WIDTH_OF_INTEGER_VARIABLE*NUMBER_OF_INTEGER_VARIABLES-1:0] out_clause_coefficients,
  output logic [NUMBER_OF_CLAUSES-1:0]                                     out_clause_write_enable,
  output logic [CLAUSE_INDEX_WIDTH-1:0]                                    out_clause_index,
  input  logic                                                             in_scan_request,
  input  logic                                                             in_scan_stall,
  output logic                                                             out_scan_valid,
  output logic [CLAUSE_INDEX_WIDTH-1:0]                                    out_scan_index,
  output logic                                                             out_load_done,
  output logic                                                             out_busy
);

  localparam int W = BIT_WIDTH_OF_INTEGER_VARIABLE * NUMBER_OF_INTEGER_VARIABLES;
  localparam int N = NUMBER_OF_CLAUSES;
  localparam logic [CLAUSE_INDEX_WIDTH-1:0] LAST_IDX = CLAUSE_INDEX_WIDTH'(NUMBER_OF_CLAUSES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_LOADED = 2'd2,
    ST_SCAN   = 2'd3
  } state_t;

  state_t                        state_q, state_d;
  logic [CLAUSE_INDEX_WIDTH-1:0] load_idx_q, load_idx_d;
  logic                          ready_q, ready_d;
  logic [W-1:0]                  data_q, data_d;
  logic [N-1:0]                  we_q, we_d;
  logic [CLAUSE_INDEX_WIDTH-1:0] widx_q, widx_d;
  logic                          scan_vld_q, scan_vld_d;
  logic [CLAUSE_INDEX_WIDTH-1:0] scan_idx_q, scan_idx_d;
  logic                          done_q, done_d;
  logic                          busy_q, busy_d;

  logic load_xfer;
  logic scan_adv;

  // A word is taken only in LOAD and only while ready is being shown.
  assign load_xfer = (state_q == ST_LOAD) && ready_q && in_coeff_valid;
  // The scan index moves on when it is shown valid and downstream is not stalling.
  assign scan_adv  = (state_q == ST_SCAN) && scan_vld_q && !in_scan_stall;

  // Next-state and next-output computation; every registered output holds by default except the write pulse.
  always_comb begin
    state_d    = state_q;
    load_idx_d = load_idx_q;
    ready_d    = ready_q;
    data_d     = data_q;
    we_d       = '0;
    widx_d     = widx_q;
    scan_vld_d = scan_vld_q;
    scan_idx_d = scan_idx_q;
    done_d     = done_q;

    case (state_q)
      ST_IDLE: begin
        // Scan requests are meaningless before anything is loaded.
        if (in_start) begin
          state_d    = ST_LOAD;
          load_idx_d = '0;
          ready_d    = 1'b1;
          done_d     = 1'b0;
        end
      end

      ST_LOAD: begin
        if (load_xfer) begin
          for (int i = 0; i < N; i++) begin
            we_d[i] = (load_idx_q == CLAUSE_INDEX_WIDTH'(i));
          end
          data_d = in_coefficients;
          widx_d = load_idx_q;
          // Explicit compare against the last clause so non-power-of-2 banks never overrun.
          if (load_idx_q == LAST_IDX) begin
            state_d = ST_LOADED;
            ready_d = 1'b0;
            done_d  = 1'b1;
          end else begin
            load_idx_d = load_idx_q + 1'b1;
          end
        end
      end

      ST_LOADED: begin
        // A reload takes priority over a scan when both arrive together.
        if (in_start) begin
          state_d    = ST_LOAD;
          load_idx_d = '0;
          ready_d    = 1'b1;
          done_d     = 1'b0;
        end else if (in_scan_request) begin
          state_d    = ST_SCAN;
          scan_vld_d = 1'b1;
          scan_idx_d = '0;
        end
      end

      ST_SCAN: begin
        if (scan_adv) begin
          if (scan_idx_q == LAST_IDX) begin
            state_d    = ST_LOADED;
            scan_vld_d = 1'b0;
          end else begin
            scan_idx_d = scan_idx_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_LOAD) || (state_d == ST_SCAN);
  end

  // State and all registered outputs; synchronous reset clears everything and suppresses any pending pulse.
  always_ff @(posedge in_clk) begin
    if (!in_reset) begin
      state_q    <= ST_IDLE;
      load_idx_q <= '0;
      ready_q    <= 1'b0;
      data_q     <= '0;
      we_q       <= '0;
      widx_q     <= '0;
      scan_vld_q <= 1'b0;
      scan_idx_q <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      load_idx_q <= load_idx_d;
      ready_q    <= ready_d;
      data_q     <= data_d;
      we_q       <= we_d;
      widx_q     <= widx_d;
      scan_vld_q <= scan_vld_d;
      scan_idx_q <= scan_idx_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  assign out_coeff_ready         = ready_q;
  assign out_clause_coefficients = data_q;
  assign out_clause_write_enable = we_q;
  assign out_clause_index        = widx_q;
  assign out_scan_valid          = scan_vld_q;
  assign out_scan_index          = scan_idx_q;
  assign out_load_done           = done_q;
  assign out_busy                = busy_q;

endmodule

// File: tb/tb_clause_load_scan_controller.sv
// Bench for clause_load_scan_controller: directed scenarios plus randomized traffic.
// Expected outputs come from a phase-level reference model updated once per clock edge.
// All outputs are compared 1 time unit after each rising edge.
module tb_clause_load_scan_controller;

  localparam int BW = 2;
  localparam int NV = 2;
  localparam int N  = 4;
  localparam int CW = 2;
  localparam int W  = BW * NV;

  localparam int P_IDLE   = 0;
  localparam int P_LOAD   = 1;
  localparam int P_LOADED = 2;
  localparam int P_SCAN   = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          valid;
  logic [W-1:0]  coef;
  logic          scan_req;
  logic          stall;
  logic          ready;
  logic [W-1:0]  wdata;
  logic [N-1:0]  we;
  logic [CW-1:0] widx;
  logic          scan_vld;
  logic [CW-1:0] scan_idx;
  logic          load_done;
  logic          busy;

  always #5 clk = ~clk;

  clause_load_scan_controller #(
    .BIT_WIDTH_OF_INTEGER_VARIABLE(BW),
    .NUMBER_OF_INTEGER_VARIABLES(NV),
    .NUMBER_OF_CLAUSES(N),
    .CLAUSE_INDEX_WIDTH(CW)
  ) dut (
    .in_clk(clk),
    .in_reset(rst_n),
    .in_start(start),
    .in_coeff_valid(valid),
    .in_coefficients(coef),
    .out_coeff_ready(ready),
    .out_clause_coefficients(wdata),
    .out_clause_write_enable(we),
    .out_clause_index(widx),
    .in_scan_request(scan_req),
    .in_scan_stall(stall),
    .out_scan_valid(scan_vld),
    .out_scan_index(scan_idx),
    .out_load_done(load_done),
    .out_busy(busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: phase, load count, and the expected value of every output.
  int            m_phase = P_IDLE;
  int            m_cnt   = 0;
  logic          m_xfer;
  logic          e_ready, e_sv, e_done, e_busy;
  logic [W-1:0]  e_data;
  logic [N-1:0]  e_we;
  logic [CW-1:0] e_idx, e_si;

  task automatic model_enter_load();
    m_phase = P_LOAD;
    m_cnt   = 0;
    e_ready = 1'b1;
    e_done  = 1'b0;
  endtask

  task automatic model_edge();
    m_xfer = 1'b0;
    e_we   = '0;
    if (!rst_n) begin
      m_phase = P_IDLE;
      m_cnt   = 0;
      e_ready = 0; e_data = 0; e_idx = 0; e_sv = 0; e_si = 0; e_done = 0;
    end else begin
      case (m_phase)
        P_IDLE: if (start) model_enter_load();
        P_LOAD: if (valid && e_ready) begin
          m_xfer = 1'b1;
          e_we   = N'(1 << m_cnt);
          e_data = coef;
          e_idx  = CW'(m_cnt);
          if (m_cnt == N - 1) begin
            m_phase = P_LOADED;
            e_ready = 1'b0;
            e_done  = 1'b1;
          end else begin
            m_cnt = m_cnt + 1;
          end
        end
        P_LOADED: begin
          if (start) model_enter_load();
          else if (scan_req) begin
            m_phase = P_SCAN;
            e_sv    = 1'b1;
            e_si    = '0;
          end
        end
        default: if (!stall) begin
          if (int'(e_si) == N - 1) begin
            e_sv    = 1'b0;
            m_phase = P_LOADED;
          end else begin
            e_si = e_si + 1'b1;
          end
        end
      endcase
    end
    e_busy = (m_phase == P_LOAD) || (m_phase == P_SCAN);
  endtask

  // Logs of observed write pulses and scan indices for the directed scenarios.
  logic [N-1:0]  we_log[$];
  logic [W-1:0]  dat_log[$];
  logic [CW-1:0] idx_log[$];
  logic [CW-1:0] scan_log[$];

  task automatic compare_all();
    check("ready", ready, e_ready);
    check("wdata", wdata, e_data);
    check("we", we, e_we);
    check("widx", widx, e_idx);
    check("scan_vld", scan_vld, e_sv);
    check("scan_idx", scan_idx, e_si);
    check("load_done", load_done, e_done);
    check("busy", busy, e_busy);
    check("we_onehot0", $onehot0(we), 1);
    check("sv_we_excl", scan_vld && (we != '0), 0);
  endtask

  task automatic step(input logic r, input logic s, input logic v, input logic [W-1:0] c,
                      input logic sr, input logic st);
    rst_n = r; start = s; valid = v; coef = c; scan_req = sr; stall = st;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
    if (we != '0) begin
      we_log.push_back(we);
      dat_log.push_back(wdata);
      idx_log.push_back(widx);
    end
    if (scan_vld) scan_log.push_back(scan_idx);
  endtask

  // Feeds four words, optionally dropping valid for gap_len cycles after word gap_after is taken.
  task automatic load_words(input logic [W-1:0] w0, input logic [W-1:0] w1,
                            input logic [W-1:0] w2, input logic [W-1:0] w3,
                            input int gap_after, input int gap_len);
    logic [W-1:0] w[4];
    int p;
    int budget;
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    p = 0;
    budget = 0;
    while (p < N && budget < 40) begin
      step(1, 0, 1, w[p], 0, 0);
      budget++;
      if (m_xfer) begin
        if (p == gap_after) begin
          for (int g = 0; g < gap_len; g++) begin
            step(1, 0, 0, w[p], 0, 0);
            check("gap_no_pulse", we, 0);
          end
        end
        p++;
      end
    end
    if (p < N) check("load_budget", p, N);
  endtask

  initial begin
    logic [N-1:0]  exp_we [4];
    logic [W-1:0]  exp_dat[4];
    logic [CW-1:0] exp_scan[7];
    exp_we   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    exp_dat  = '{4'd1, 4'd7, 4'd8, 4'd9};
    exp_scan = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd3};

    // 1: reset, then load 1,7,8,9 with valid held high
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    check("t1_reset_ready", ready, 0);
    check("t1_reset_done", load_done, 0);
    step(1, 1, 0, 0, 0, 0);
    check("t1_ready_after_start", ready, 1);
    we_log.delete(); dat_log.delete(); idx_log.delete();
    for (int i = 0; i < N; i++) begin
      step(1, 0, 1, exp_dat[i], 0, 0);
      check("t1_pulse_each_cycle", we, exp_we[i]);
    end
    check("t1_done_with_last", load_done, 1);
    step(1, 0, 1, 4'd5, 0, 0);
    check("t1_ready_after", ready, 0);
    check("t1_pulse_count", we_log.size(), 4);
    for (int i = 0; i < we_log.size() && i < 4; i++) begin
      check("t1_we", we_log[i], exp_we[i]);
      check("t1_dat", dat_log[i], exp_dat[i]);
      check("t1_idx", idx_log[i], i);
    end

    // 2: reload with a 2-cycle valid gap between words 7 and 8
    step(1, 1, 0, 0, 0, 0);
    we_log.delete(); dat_log.delete(); idx_log.delete();
    load_words(4'd1, 4'd7, 4'd8, 4'd9, 1, 2);
    check("t2_pulse_count", we_log.size(), 4);
    if (we_log.size() == 4) begin
      check("t2_word8_we", we_log[2], 4'b0100);
      check("t2_word8_dat", dat_log[2], 8);
      check("t2_word8_idx", idx_log[2], 2);
    end

    // 3: scan with a 3-cycle stall at index 1
    scan_log.delete();
    step(1, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0);
    repeat (3) step(1, 0, 0, 0, 0, 1);
    repeat (3) step(1, 0, 0, 0, 0, 0);
    check("t3_scan_len", scan_log.size(), 7);
    for (int i = 0; i < scan_log.size() && i < 7; i++) check("t3_scan_seq", scan_log[i], exp_scan[i]);
    check("t3_busy_end", busy, 0);
    check("t3_done_end", load_done, 1);

    // 4: start and scan request together in LOADED
    step(1, 1, 0, 0, 1, 0);
    check("t4_done_cleared", load_done, 0);
    check("t4_no_scan", scan_vld, 0);
    check("t4_busy", busy, 1);

    // 5: reset after two transfers aborts the load
    step(1, 0, 1, 4'd3, 0, 0);
    step(1, 0, 1, 4'd4, 0, 0);
    step(0, 0, 1, 4'd6, 0, 0);
    check("t5_no_pulse", we, 0);
    check("t5_data_zero", wdata, 0);
    check("t5_ready_zero", ready, 0);
    step(1, 1, 0, 0, 0, 0);
    we_log.delete(); idx_log.delete(); dat_log.delete();
    load_words(4'd2, 4'd4, 4'd6, 4'd15, -1, 0);
    check("t5_reload_count", we_log.size(), 4);
    if (we_log.size() > 0) check("t5_reload_first_idx", idx_log[0], 0);

    // 6: start ignored during scan; scan request ignored in IDLE
    scan_log.delete();
    step(1, 0, 0, 0, 1, 0);
    step(1, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 1, 0);
    repeat (3) step(1, 0, 0, 0, 0, 0);
    check("t6_scan_len", scan_log.size(), 4);
    for (int i = 0; i < scan_log.size() && i < 4; i++) check("t6_scan_seq", scan_log[i], i);
    step(0, 0, 0, 0, 0, 0);
    repeat (3) step(1, 0, 1, 4'd9, 1, 0);
    check("t6_idle_sv", scan_vld, 0);
    check("t6_idle_busy", busy, 0);
    check("t6_idle_ready", ready, 0);

    // Randomized traffic against the model
    for (int cyc = 0; cyc < 3000; cyc++) begin
      step(($urandom_range(0, 99) != 0),
           ($urandom_range(0, 99) < 6),
           ($urandom_range(0, 99) < 60),
           W'($urandom),
           ($urandom_range(0, 99) < 25),
           ($urandom_range(0, 99) < 30));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clause_load_scan_controller.md
Name: clause_load_scan_controller

Overview:
- Sequences a bank of NUMBER_OF_CLAUSES integer-literal clause registers.
- LOAD phase: accepts a stream of packed clause-coefficient words over a valid/ready handshake and writes them to clause registers 0..N-1 in order, with one-hot write-enable pulses.
- SCAN phase: steps a clause index 0..N-1 under a stall-able handshake so the downstream evaluator reads each clause once per sweep.
- Sits between the constraint-loading front end and the clause register bank / clause evaluator.

Parameters:
- BIT_WIDTH_OF_INTEGER_VARIABLE, 2, bits per coefficient.
- NUMBER_OF_INTEGER_VARIABLES, 2, coefficients per clause.
- NUMBER_OF_CLAUSES, 4, clause registers managed (N >= 2, need not be a power of 2).
- CLAUSE_INDEX_WIDTH, 2, index width; must satisfy 2^CLAUSE_INDEX_WIDTH >= NUMBER_OF_CLAUSES.
- Let W = BIT_WIDTH_OF_INTEGER_VARIABLE*NUMBER_OF_INTEGER_VARIABLES.

Ports:
- in_clk  input  1  sole clock, rising edge.
- in_reset  input  1  synchronous active-low reset; sampled on the in_clk rising edge.
- in_start  input  1  begin a (re)load of all clauses.
- in_coeff_valid  input  1  in_coefficients is valid.
- in_coefficients  input  W  packed coefficients of the next clause.
- out_coeff_ready  output  1  controller accepts a word this cycle.
- out_clause_coefficients  output  W  registered write data to the bank.
- out_clause_write_enable  output  NUMBER_OF_CLAUSES  one-hot write pulse.
- out_clause_index  output  CLAUSE_INDEX_WIDTH  index of the clause being written.
- in_scan_request  input  1  start one scan sweep.
- in_scan_stall  input  1  downstream cannot take the current scan index.
- out_scan_valid  output  1  out_scan_index is valid.
- out_scan_index  output  CLAUSE_INDEX_WIDTH  clause to evaluate.
- out_load_done  output  1  all N clauses loaded since the last start.
- out_busy  output  1  state is LOAD or SCAN.

Behaviour:
- Reset (in_reset=0 at an edge):
  - state=IDLE, counters=0.
  - Every output =0, including write-enable, data and load_done.
  - Overrides all other inputs. Reset mid-LOAD or mid-SCAN aborts; no write pulse follows reset.
- All outputs are registered.
- FSM states: IDLE, LOAD, LOADED, SCAN.
- IDLE:
  - ready=0.
  - in_start -> LOAD, load index=0, load_done=0.
  - in_scan_request is ignored.
- LOAD:
  - out_coeff_ready=1 from the cycle after start is sampled.
  - Transfer happens on a cycle with valid & ready.
  - On a transfer at index k, the next cycle shows write_enable=one-hot(k), out_clause_index=k, out_clause_coefficients=captured word. Latency is 1 cycle; the pulse lasts exactly 1 cycle, otherwise write_enable=0.
  - Data/index outputs hold their last values between pulses.
  - Index compares to N-1 explicitly and never wraps past N-1.
  - Transfer at k=N-1: ready=0 next cycle, state -> LOADED, load_done=1 in the same cycle as the last write pulse.
  - valid while ready=0: ignored, no write.
  - in_start and in_scan_request are ignored in LOAD.
- LOADED:
  - load_done holds 1.
  - in_start -> LOAD (clears load_done, index 0).
  - in_scan_request -> SCAN.
  - If both assert together, start wins.
- SCAN:
  - Entry cycle: out_scan_valid=1, out_scan_index=0.
  - Index advances only on a cycle with valid & !stall.
  - While stall=1, index and valid are held.
  - Advance accepted at N-1: valid=0 next cycle, state -> LOADED.
  - in_start and in_scan_request are ignored during SCAN.
- out_busy=1 exactly in LOAD and SCAN.
- Invariants:
  - write_enable is one-hot or zero.
  - write_enable never asserts outside the cycle after a LOAD transfer.
  - scan_valid and write_enable are never both 1.

Test Plan:
1. Reset then load, N=4, words 1,7,8,9 with valid held high: ready rises 1 cycle after start. Pulses 0001/0010/0100/1000 occur on consecutive cycles with data 1,7,8,9 and index 0..3. load_done=1 with the 1000 pulse; ready=0 after it.
2. Valid gaps (valid low 2 cycles between words 7 and 8): no pulse during the gaps. Word 8 is written to index 2 only; total pulses=4.
3. Scan with stall held for 3 cycles at index 1: sequence 0,1,1,1,1,2,3. scan_valid then drops and state returns to LOADED (busy=0, load_done=1).
4. Start and scan_request together in LOADED: LOAD entered, load_done=0, scan_valid stays 0.
5. Reset asserted low mid-LOAD after 2 transfers: the next cycle shows all outputs 0 and no write pulse. A new start loads from index 0.
6. Start during SCAN, and scan_request in IDLE: both ignored. Scan completes 0..3; IDLE outputs stay 0.
